// File: rtl/bomberman_pkg.sv
// Shared constants for the bomberman datapath: direction codes, NES pad bit order, pad poll FSM states.
package bomberman_pkg;

  localparam logic [1:0] CD_U = 2'b00;
  localparam logic [1:0] CD_R = 2'b01;
  localparam logic [1:0] CD_D = 2'b10;
  localparam logic [1:0] CD_L = 2'b11;

  // Serial order in which the pad shifts its buttons out
  localparam int PAD_A      = 0;
  localparam int PAD_B      = 1;
  localparam int PAD_SELECT = 2;
  localparam int PAD_START  = 3;
  localparam int PAD_UP     = 4;
  localparam int PAD_DOWN   = 5;
  localparam int PAD_LEFT   = 6;
  localparam int PAD_RIGHT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_UPDATE   = 3'd4
  } pad_state_t;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data line; resets to 1 (released).
module pad_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/nes_pad_reader.sv
// Polls an NES serial pad once per frame and decodes held direction, current direction and bomb press.
// Outputs load together with the frame_done pulse, so they are stable for a whole poll period.
module nes_pad_reader
  import bomberman_pkg::*;
#(
  parameter int POLL_CYCLES = 1_666_666,
  parameter int HALF_BIT    = 600,
  parameter int NUM_BITS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic       L,
  output logic       R,
  output logic       U,
  output logic       D,
  output logic [1:0] cd,
  output logic       bomb_pulse,
  output logic       frame_done
);

  localparam int              HB_W       = $clog2(2 * HALF_BIT);
  localparam logic [HB_W-1:0] LATCH_LAST = HB_W'(2 * HALF_BIT - 1);
  localparam logic [HB_W-1:0] HALF_LAST  = HB_W'(HALF_BIT - 1);
  localparam logic [20:0]     POLL_LAST  = 21'(POLL_CYCLES - 1);
  localparam logic [2:0]      BIT_LAST   = 3'(NUM_BITS - 1);

  pad_state_t          r_state;
  logic [20:0]         r_poll;
  logic [HB_W-1:0]     r_half;
  logic [2:0]          r_bit_idx;
  logic [NUM_BITS-1:0] r_shift;
  logic                r_prev_a;

  logic       w_pad;
  logic       w_poll_wrap;
  logic       w_a;
  logic       w_up;
  logic       w_dn;
  logic       w_lf;
  logic       w_rt;
  logic [1:0] w_cd_next;

  pad_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (pad_data),
    .o_q     (w_pad)
  );

  assign w_poll_wrap = (r_poll == POLL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_poll <= '0;
    end else if (w_poll_wrap) begin
      r_poll <= '0;
    end else begin
      r_poll <= r_poll + 21'd1;
    end
  end

  // Bits arrive LSB first and enter at the top, so after NUM_BITS samples bit i holds button i
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_half    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_half <= '0;
          if (w_poll_wrap) r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          if (r_half == LATCH_LAST) begin
            r_half    <= '0;
            r_shift   <= {w_pad, r_shift[NUM_BITS-1:1]};
            r_bit_idx <= 3'd1;
            r_state   <= ST_SHIFT_LO;
          end else begin
            r_half <= r_half + 1'b1;
          end
        end
        ST_SHIFT_LO: begin
          if (r_half == HALF_LAST) begin
            r_half  <= '0;
            r_state <= ST_SHIFT_HI;
          end else begin
            r_half <= r_half + 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (r_half == HALF_LAST) begin
            r_half  <= '0;
            r_shift <= {w_pad, r_shift[NUM_BITS-1:1]};
            if (r_bit_idx == BIT_LAST) begin
              r_state <= ST_UPDATE;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_state   <= ST_SHIFT_LO;
            end
          end else begin
            r_half <= r_half + 1'b1;
          end
        end
        ST_UPDATE: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign pad_latch = (r_state == ST_LATCH);
  assign pad_clk   = (r_state != ST_SHIFT_LO);

  // Pad is active-low; opposing pairs cancel, then U > D > L > R
  assign w_a  = ~r_shift[PAD_A];
  assign w_up = ~r_shift[PAD_UP] & r_shift[PAD_DOWN];
  assign w_dn = ~r_shift[PAD_DOWN] & r_shift[PAD_UP];
  assign w_lf = ~r_shift[PAD_LEFT] & r_shift[PAD_RIGHT] & ~w_up & ~w_dn;
  assign w_rt = ~r_shift[PAD_RIGHT] & r_shift[PAD_LEFT] & ~w_up & ~w_dn;

  always_comb begin
    w_cd_next = cd;
    if (w_up)      w_cd_next = CD_U;
    else if (w_dn) w_cd_next = CD_D;
    else if (w_lf) w_cd_next = CD_L;
    else if (w_rt) w_cd_next = CD_R;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      L          <= 1'b0;
      R          <= 1'b0;
      U          <= 1'b0;
      D          <= 1'b0;
      cd         <= CD_D;
      bomb_pulse <= 1'b0;
      frame_done <= 1'b0;
      r_prev_a   <= 1'b0;
    end else begin
      frame_done <= (r_state == ST_UPDATE);
      bomb_pulse <= (r_state == ST_UPDATE) & w_a & ~r_prev_a;
      if (r_state == ST_UPDATE) begin
        U        <= w_up;
        D        <= w_dn;
        L        <= w_lf;
        R        <= w_rt;
        cd       <= w_cd_next;
        r_prev_a <= w_a;
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural pad model, per-frame expectation queue, monitor on frame_done.
module tb_nes_pad_reader;

  localparam int HB = 4;
  localparam int PC = 200;

  typedef struct packed {
    logic       u;
    logic       d;
    logic       l;
    logic       r;
    logic [1:0] cd;
    logic       bomb;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic       L, R, U, D;
  logic [1:0] cd;
  logic       bomb_pulse;
  logic       frame_done;

  logic [7:0] buttons_n = 8'hFF;
  logic [7:0] pad_sr = 8'hFF;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [1:0] m_cd = 2'b10;
  logic       m_prev_a = 1'b0;
  logic [5:0] last_out;
  logic       stray_pulse = 1'b0;
  logic       stray_change = 1'b0;

  nes_pad_reader #(
    .POLL_CYCLES (PC),
    .HALF_BIT    (HB),
    .NUM_BITS    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .L          (L),
    .R          (R),
    .U          (U),
    .D          (D),
    .cd         (cd),
    .bomb_pulse (bomb_pulse),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // 4021-style pad: parallel load while latched, shift toward bit 0 on pad_clk rise
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_sr <= buttons_n;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  end
  assign pad_data = pad_sr[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: net vertical / horizontal intent, vertical wins, Up and Left on ties of priority
  task automatic issue(input logic [7:0] b);
    logic [7:0] p;
    int   vert;
    int   horiz;
    exp_t e;
    p     = ~b;
    vert  = (p[4] ? 1 : 0) - (p[5] ? 1 : 0);
    horiz = (p[7] ? 1 : 0) - (p[6] ? 1 : 0);
    e     = '0;
    e.cd  = m_cd;
    if (vert > 0)       begin e.u = 1'b1; e.cd = 2'b00; end
    else if (vert < 0)  begin e.d = 1'b1; e.cd = 2'b10; end
    else if (horiz < 0) begin e.l = 1'b1; e.cd = 2'b11; end
    else if (horiz > 0) begin e.r = 1'b1; e.cd = 2'b01; end
    e.bomb    = p[0] && !m_prev_a;
    m_prev_a  = p[0];
    m_cd      = e.cd;
    buttons_n = b;
    q.push_back(e);
  endtask

  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * PC && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (frame_done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: frame_done with no frame outstanding");
        end else begin
          mon_e = q.pop_front();
          check("frame_outputs", 32'({U, D, L, R, cd, bomb_pulse}), 32'(mon_e));
        end
      end else begin
        if (bomb_pulse) stray_pulse = 1'b1;
        if ({L, R, U, D, cd} !== last_out) stray_change = 1'b1;
      end
    end
    last_out = {L, R, U, D, cd};
  end

  logic [7:0] dir_tbl [15];
  logic [7:0] rb;
  int         cnt;
  int         falls;
  logic       prev_pc;

  initial begin
    dir_tbl = '{8'hEF, 8'hAF, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFE, 8'hFE,
                8'hFF, 8'hFE, 8'hDF, 8'hBF, 8'h8F, 8'h0F, 8'hFF};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_cd", 32'(cd), 32'd2);
    check("rst_dirs", 32'({L, R, U, D}), 32'd0);
    check("rst_pad_clk", 32'(pad_clk), 32'd1);
    check("rst_pad_latch", 32'(pad_latch), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_bomb", 32'(bomb_pulse), 32'd0);

    issue(8'hFF);
    for (int i = 0; i < 2 * PC && !pad_latch; i++) @(negedge clk);
    cnt = 0;
    while (pad_latch && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("latch_width", 32'(cnt), 32'(2 * HB));
    wait_frame();

    foreach (dir_tbl[i]) begin
      issue(dir_tbl[i]);
      wait_frame();
    end

    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      issue(rb);
      wait_frame();
    end

    issue(8'hFE);
    wait_frame();

    // Interrupt a frame partway through the shift phase
    buttons_n = 8'hBE;
    for (int i = 0; i < 2 * PC && !pad_latch; i++) @(negedge clk);
    falls   = 0;
    prev_pc = pad_clk;
    for (int i = 0; i < 300 && falls < 4; i++) begin
      @(negedge clk);
      if (prev_pc && !pad_clk) falls++;
      prev_pc = pad_clk;
    end
    check("reached_bit4", 32'(falls), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("midrst_cd", 32'(cd), 32'd2);
    check("midrst_dirs", 32'({L, R, U, D}), 32'd0);
    check("midrst_pad_clk", 32'(pad_clk), 32'd1);
    check("midrst_pad_latch", 32'(pad_latch), 32'd0);
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    m_cd     = 2'b10;
    m_prev_a = 1'b0;
    issue(8'hBE);
    wait_frame();
    issue(8'hFF);
    wait_frame();

    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("no_stray_bomb", 32'(stray_pulse), 32'd0);
    check("outputs_stable", 32'(stray_change), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
